// File: rtl/train_step_sequencer_pkg.sv
// rtl/train_step_sequencer_pkg.sv - shared state encoding and width defaults for the training-step sequencer
package train_step_sequencer_pkg;

    localparam int IDX_W_DEF  = 32;
    localparam int DATA_W_DEF = 48;
    localparam int CYC_W_DEF  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOC_RST = 3'd1,
        ST_RUN     = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/train_step_sequencer_if.sv
// rtl/train_step_sequencer_if.sv - weight-storage update bus between sequencer and weight storage
interface train_step_sequencer_if
    import train_step_sequencer_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              is_update;
    logic [DATA_W-1:0] dc_dw;
    logic [IDX_W-1:0]  layer_index;
    logic [IDX_W-1:0]  row_index;

    modport master (output is_update, output dc_dw, output layer_index, output row_index);
    modport slave  (input  is_update, input  dc_dw, input  layer_index, input  row_index);
endinterface

// File: rtl/train_step_sequencer_layer_row_walker.sv
// rtl/train_step_sequencer_layer_row_walker.sv - layer-major nested layer/row location counter
module layer_row_walker
    import train_step_sequencer_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [IDX_W-1:0] layer_count,
    input  logic [IDX_W-1:0] row_count,
    output logic [IDX_W-1:0] layer_idx,
    output logic [IDX_W-1:0] row_idx,
    output logic             last
);

    logic row_last;
    logic layer_last;

    assign row_last   = (row_idx == row_count - IDX_W'(1));
    assign layer_last = (layer_idx == layer_count - IDX_W'(1));
    assign last       = row_last && layer_last;

    // load returns to the (0,0) origin; step advances row first, carrying into layer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_idx <= '0;
            row_idx   <= '0;
        end else if (load) begin
            layer_idx <= '0;
            row_idx   <= '0;
        end else if (step) begin
            if (row_last) begin
                row_idx   <= '0;
                layer_idx <= layer_idx + IDX_W'(1);
            end else begin
                row_idx <= row_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/train_step_sequencer.sv
// rtl/train_step_sequencer.sv - sequences locator reset, controller run and the weight-update sweep
module train_step_sequencer
    import train_step_sequencer_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CYC_W  = CYC_W_DEF
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CYC_W-1:0]         cfg_run_cycles,
    input  logic [IDX_W-1:0]         cfg_layer_count,
    input  logic [IDX_W-1:0]         cfg_row_count,
    input  logic [DATA_W-1:0]        dc_dw_stream,
    output logic                     locator_reset,
    output logic                     controller_enable,
    train_step_sequencer_if.master   upd,
    output logic                     busy,
    output logic                     done
);

    state_e           state_q, state_d;
    logic [CYC_W-1:0] run_cycles_q;
    logic [CYC_W-1:0] run_cnt_q;
    logic [IDX_W-1:0] layer_count_q;
    logic [IDX_W-1:0] row_count_q;
    logic             have_sweep;
    logic             walk_load, walk_step, walk_last;
    logic [IDX_W-1:0] walk_layer, walk_row;
    logic             nxt_locator_reset, nxt_controller_enable, nxt_is_update, nxt_busy, nxt_done;

    assign have_sweep = (layer_count_q != '0) && (row_count_q != '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_LOC_RST;
            ST_LOC_RST: begin
                if (run_cycles_q != '0) state_d = ST_RUN;
                else if (have_sweep)    state_d = ST_UPDATE;
                else                    state_d = ST_DONE;
            end
            ST_RUN:     if (run_cnt_q == CYC_W'(1)) state_d = have_sweep ? ST_UPDATE : ST_DONE;
            ST_UPDATE:  if (walk_last) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;

        // outputs are decoded from the next state so the registered copies line up with state_q
        nxt_locator_reset     = (state_d == ST_LOC_RST);
        nxt_controller_enable = (state_d == ST_RUN);
        nxt_is_update         = (state_d == ST_UPDATE);
        nxt_busy              = (state_d != ST_IDLE);
        nxt_done              = (state_d == ST_DONE);
    end

    // the walker registers double as the index outputs, so they are held at 0 outside UPDATE
    assign walk_load = (state_d != ST_UPDATE);
    assign walk_step = (state_q == ST_UPDATE) && (state_d == ST_UPDATE);

    layer_row_walker #(.IDX_W(IDX_W)) u_walker (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .load        (walk_load),
        .step        (walk_step),
        .layer_count (layer_count_q),
        .row_count   (row_count_q),
        .layer_idx   (walk_layer),
        .row_idx     (walk_row),
        .last        (walk_last)
    );

    assign upd.layer_index = walk_layer;
    assign upd.row_index   = walk_row;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q           <= ST_IDLE;
            run_cycles_q      <= '0;
            run_cnt_q         <= '0;
            layer_count_q     <= '0;
            row_count_q       <= '0;
            locator_reset     <= 1'b0;
            controller_enable <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            upd.is_update     <= 1'b0;
            upd.dc_dw         <= '0;
        end else begin
            state_q           <= state_d;
            locator_reset     <= nxt_locator_reset;
            controller_enable <= nxt_controller_enable;
            busy              <= nxt_busy;
            done              <= nxt_done;
            upd.is_update     <= nxt_is_update;
            upd.dc_dw         <= nxt_is_update ? dc_dw_stream : '0;

            if (state_q == ST_IDLE && state_d == ST_LOC_RST) begin
                run_cycles_q  <= cfg_run_cycles;
                layer_count_q <= cfg_layer_count;
                row_count_q   <= cfg_row_count;
            end

            if (state_d != ST_RUN)         run_cnt_q <= '0;
            else if (state_q != ST_RUN)    run_cnt_q <= run_cycles_q;
            else                           run_cnt_q <= run_cnt_q - CYC_W'(1);
        end
    end

endmodule

// File: tb/tb_train_step_sequencer.sv
// tb/tb_train_step_sequencer.sv - scoreboard bench for train_step_sequencer
module tb_train_step_sequencer;

    typedef struct packed {
        logic        lr;
        logic        ce;
        logic        upd;
        logic [47:0] dc;
        logic [31:0] layer;
        logic [31:0] row;
        logic        busy;
        logic        done;
    } obs_t;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_run_cycles = '0;
    logic [31:0] cfg_layer_count = '0;
    logic [31:0] cfg_row_count = '0;
    logic [47:0] dc_dw_stream = '0;
    logic [47:0] stream_at_edge = '0;
    logic        locator_reset, controller_enable, busy, done;
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    obs_t        sb[$];
    obs_t        exp_o, act_o;

    train_step_sequencer_if #(.IDX_W(32), .DATA_W(48)) upd_if ();

    train_step_sequencer #(.IDX_W(32), .DATA_W(48), .CYC_W(32)) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .start             (start),
        .abort             (abort),
        .cfg_run_cycles    (cfg_run_cycles),
        .cfg_layer_count   (cfg_layer_count),
        .cfg_row_count     (cfg_row_count),
        .dc_dw_stream      (dc_dw_stream),
        .locator_reset     (locator_reset),
        .controller_enable (controller_enable),
        .upd               (upd_if),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk_clk = ~clk_clk;

    initial forever begin
        @(negedge clk_clk);
        cyc = cyc + 1;
        dc_dw_stream = 48'(cyc);
    end

    always @(posedge clk_clk) stream_at_edge = dc_dw_stream;

    function automatic obs_t mk(input logic lr, input logic ce, input logic up,
                                input int l, input int r, input logic bz, input logic dn);
        obs_t o;
        o = '0;
        o.lr = lr; o.ce = ce; o.upd = up; o.layer = 32'(l); o.row = 32'(r);
        o.busy = bz; o.done = dn;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.lr = locator_reset; o.ce = controller_enable; o.upd = upd_if.is_update;
        o.dc = upd_if.dc_dw; o.layer = upd_if.layer_index; o.row = upd_if.row_index;
        o.busy = busy; o.done = done;
        return o;
    endfunction

    task automatic push_step(input int run, input int nl, input int nr);
        sb.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < run; i++) sb.push_back(mk(0, 1, 0, 0, 0, 1, 0));
        if (nl > 0 && nr > 0)
            for (int l = 0; l < nl; l++)
                for (int r = 0; r < nr; r++) sb.push_back(mk(0, 0, 1, l, r, 1, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 1, 1));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic launch(input int run, input int nl, input int nr);
        @(negedge clk_clk);
        cfg_run_cycles = 32'(run); cfg_layer_count = 32'(nl); cfg_row_count = 32'(nr);
        start = 1'b1;
        push_step(run, nl, nr);
    endtask

    task automatic test_reset();
        #1;
        act_o = observe();
        total_cnt++;
        if (act_o !== '0) $display("FAIL reset_hold act=%h exp=0", act_o);
        else pass_cnt++;
        @(negedge clk_clk); reset_reset_n = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk_clk); #1;
            exp_o = sb.pop_front();
            act_o = observe();
            total_cnt++;
            if (act_o !== exp_o) $display("FAIL reset_idle c%0d act=%h exp=%h", i, act_o, exp_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic(input string nm, input int run, input int nl, input int nr);
        launch(run, nl, nr);
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk_clk); #1;
            start = 1'b0;
            exp_o = sb.pop_front();
            if (exp_o.upd) exp_o.dc = stream_at_edge;
            act_o = observe();
            total_cnt++;
            if (act_o !== exp_o) $display("FAIL %s c%0d act=%h exp=%h", nm, i, act_o, exp_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        @(negedge clk_clk);
        cfg_run_cycles = 1; cfg_layer_count = 2; cfg_row_count = 2;
        start = 1'b1;
        sb.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        sb.push_back(mk(0, 1, 0, 0, 0, 1, 0));
        sb.push_back(mk(0, 0, 1, 0, 0, 1, 0));
        sb.push_back(mk(0, 0, 1, 0, 1, 1, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk_clk); #1;
            start = 1'b0;
            abort = (i == 3);
            exp_o = sb.pop_front();
            if (exp_o.upd) exp_o.dc = stream_at_edge;
            act_o = observe();
            total_cnt++;
            if (act_o !== exp_o) $display("FAIL abort c%0d act=%h exp=%h", i, act_o, exp_o);
            else pass_cnt++;
        end
        abort = 1'b0;
        // start and abort together must leave the block idle
        @(negedge clk_clk);
        start = 1'b1; abort = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk_clk); #1;
            start = 1'b0; abort = 1'b0;
            exp_o = sb.pop_front();
            act_o = observe();
            total_cnt++;
            if (act_o !== exp_o) $display("FAIL start_abort c%0d act=%h exp=%h", i, act_o, exp_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_midstep_changes();
        launch(4, 1, 2);
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk_clk); #1;
            start = (i == 1);
            if (i == 1) begin
                cfg_run_cycles = 1; cfg_layer_count = 3; cfg_row_count = 3;
            end
            exp_o = sb.pop_front();
            if (exp_o.upd) exp_o.dc = stream_at_edge;
            act_o = observe();
            total_cnt++;
            if (act_o !== exp_o) $display("FAIL midstep c%0d act=%h exp=%h", i, act_o, exp_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        launch(5, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_clk); #1;
            start = 1'b0;
            exp_o = sb.pop_front();
            act_o = observe();
            total_cnt++;
            if (act_o !== exp_o) $display("FAIL areset_pre c%0d act=%h exp=%h", i, act_o, exp_o);
            else pass_cnt++;
        end
        sb.delete();
        #1 reset_reset_n = 1'b0;
        #1;
        act_o = observe();
        total_cnt++;
        if (act_o !== '0) $display("FAIL areset_mid act=%h exp=0", act_o);
        else pass_cnt++;
        @(negedge clk_clk); reset_reset_n = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk_clk); #1;
            exp_o = sb.pop_front();
            act_o = observe();
            total_cnt++;
            if (act_o !== exp_o) $display("FAIL areset_post c%0d act=%h exp=%h", i, act_o, exp_o);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic_r3_l2_r2", 3, 2, 2);
        test_basic("no_run_l1_r3", 0, 1, 3);
        test_basic("zero_layers", 2, 0, 5);
        test_basic("zero_all", 0, 0, 0);
        test_abort();
        test_basic("after_abort", 1, 2, 2);
        test_midstep_changes();
        test_async_reset();
        test_basic("back_to_back_a", 1, 3, 1);
        test_basic("back_to_back_b", 2, 1, 4);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
